// File: rtl/ca_frame_sequencer.sv
// Frame sequencer for the 80-cell cellular-automaton datapath: paces generation
// steps, selects seed vs feedback, addresses image rows and holds the live rule.
module ca_frame_sequencer #(
    parameter int unsigned ROWS          = 60,
    parameter int unsigned TICK_DIV      = 524288,
    parameter int unsigned RULE_INIT     = 30,
    parameter int unsigned DEBOUNCE_BITS = 16,
    parameter int unsigned HOLD_TICKS    = 120
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       sw1,
    input  logic       sw2,
    output logic [7:0] rule,
    output logic       seed_sel,
    output logic       step,
    output logic       we,
    output logic [6:0] row_w,
    output logic       frame_done
);

    localparam int unsigned TICK_W = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
    localparam int unsigned HOLD_W = (HOLD_TICKS > 0) ? $clog2(HOLD_TICKS + 1) : 1;

    localparam logic [TICK_W-1:0]        TICK_LAST = TICK_W'(TICK_DIV - 1);
    localparam logic [TICK_W-1:0]        TICK_ONE  = TICK_W'(1);
    localparam logic [HOLD_W-1:0]        HOLD_LAST = HOLD_W'((HOLD_TICKS > 0) ? HOLD_TICKS - 1 : 0);
    localparam logic [HOLD_W-1:0]        HOLD_ONE  = HOLD_W'(1);
    localparam logic [DEBOUNCE_BITS-1:0] DB_MAX    = {DEBOUNCE_BITS{1'b1}};
    localparam logic [DEBOUNCE_BITS-1:0] DB_ONE    = DEBOUNCE_BITS'(1);
    localparam logic [6:0]               ROW_LAST  = 7'(ROWS - 1);
    localparam logic [6:0]               ROW_ONE   = 7'(1);
    localparam logic [7:0]               RULE_RST  = 8'(RULE_INIT);

    typedef enum logic [1:0] {
        ST_SEED,
        ST_RUN,
        ST_HOLD
    } state_t;

    state_t                   state;
    logic [TICK_W-1:0]        tick_cnt;
    logic [HOLD_W-1:0]        hold_cnt;
    logic [1:0]               s1_q;
    logic [1:0]               s2_q;
    logic [1:0]               s3_q;
    logic [1:0]               stable_q;
    logic [DEBOUNCE_BITS-1:0] db_cnt [2];
    logic [1:0]               press_c;
    logic                     tick_c;
    logic                     rule_inc_c;
    logic                     rule_dec_c;
    logic                     restart_c;

    // Two-flop synchronisers plus one history flop for change detection.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            s1_q <= '0;
            s2_q <= '0;
            s3_q <= '0;
        end else begin
            s1_q <= {sw2, sw1};
            s2_q <= s1_q;
            s3_q <= s2_q;
        end
    end

    // Debounce counters: restart on any level change, accept level at saturation.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            db_cnt[0] <= '0;
            db_cnt[1] <= '0;
            stable_q  <= '0;
        end else begin
            for (int i = 0; i < 2; i++) begin
                if (s2_q[i] != s3_q[i]) begin
                    db_cnt[i] <= '0;
                end else if (db_cnt[i] != DB_MAX) begin
                    db_cnt[i] <= db_cnt[i] + DB_ONE;
                end
                if (db_cnt[i] == DB_MAX) begin
                    stable_q[i] <= s3_q[i];
                end
            end
        end
    end

    // Press events (accepted 0->1 only) and the resulting rule change request.
    always_comb begin
        press_c = '0;
        for (int i = 0; i < 2; i++) begin
            press_c[i] = (db_cnt[i] == DB_MAX) && s3_q[i] && !stable_q[i];
        end
        rule_inc_c = press_c[0] && !press_c[1];
        rule_dec_c = press_c[1] && !press_c[0];
        restart_c  = rule_inc_c || rule_dec_c;
        tick_c     = (tick_cnt == TICK_LAST);
    end

    // Tick divider, rule register and frame FSM; a rule change overrides everything.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state      <= ST_SEED;
            tick_cnt   <= '0;
            hold_cnt   <= '0;
            rule       <= RULE_RST;
            row_w      <= '0;
            step       <= 1'b0;
            we         <= 1'b0;
            seed_sel   <= 1'b0;
            frame_done <= 1'b0;
        end else if (restart_c) begin
            state      <= ST_SEED;
            tick_cnt   <= '0;
            hold_cnt   <= '0;
            rule       <= rule_inc_c ? rule + 8'd1 : rule - 8'd1;
            row_w      <= '0;
            step       <= 1'b0;
            we         <= 1'b0;
            seed_sel   <= 1'b0;
            frame_done <= 1'b0;
        end else begin
            tick_cnt <= tick_c ? '0 : tick_cnt + TICK_ONE;
            step     <= tick_c && (state != ST_HOLD);
            we       <= tick_c && (state != ST_HOLD);
            case (state)
                ST_SEED: begin
                    if (step) begin
                        state    <= ST_RUN;
                        row_w    <= ROW_ONE;
                        seed_sel <= 1'b1;
                    end
                end
                ST_RUN: begin
                    if (step) begin
                        if (row_w == ROW_LAST) begin
                            state      <= ST_HOLD;
                            hold_cnt   <= '0;
                            frame_done <= 1'b1;
                        end else begin
                            row_w <= row_w + ROW_ONE;
                        end
                    end
                end
                ST_HOLD: begin
                    if (tick_c && (HOLD_TICKS != 0)) begin
                        if (hold_cnt == HOLD_LAST) begin
                            state      <= ST_SEED;
                            hold_cnt   <= '0;
                            row_w      <= '0;
                            seed_sel   <= 1'b0;
                            frame_done <= 1'b0;
                        end else begin
                            hold_cnt <= hold_cnt + HOLD_ONE;
                        end
                    end
                end
                default: begin
                    state <= ST_SEED;
                    row_w <= '0;
                end
            endcase
        end
    end

endmodule

// File: doc/ca_frame_sequencer.md
Name: ca_frame_sequencer

Overview:
- Controls the 80-cell cellular-automaton datapath that feeds the VGA image buffer.
- Generates the per-generation step strobe and the seed/feedback select.
- Generates the image row write address and write enable.
- Holds the live 8-bit rule, adjusted by board switches sw1/sw2; any rule change restarts the frame from the seed row.

Parameters:
- ROWS, 60, image rows per frame; row address range 0..ROWS-1.
- TICK_DIV, 524288, px_clk cycles per generation step; must be ≥ 2.
- RULE_INIT, 30, rule value after reset.
- DEBOUNCE_BITS, 16, a switch must be stable for 2^DEBOUNCE_BITS cycles to be accepted.
- HOLD_TICKS, 120, steps a completed frame is held before an automatic restart; 0 means hold forever.

Ports:
- clk  in  1  pixel clock (px_clk domain).
- rst  in  1  asynchronous, active-high reset.
- sw1  in  1  raw board switch; a press increments the rule.
- sw2  in  1  raw board switch; a press decrements the rule.
- rule  out  8  current rule to the automaton.
- seed_sel  out  1  0 = datapath input is SEED; 1 = datapath input is the generation register.
- step  out  1  one-cycle strobe: datapath register loads the automaton output; image row row_w is written with the datapath input.
- we  out  1  image write enable; equal to step.
- row_w  out  7  image write row.
- frame_done  out  1  high while in HOLD.

Behaviour:
- Reset (async, while rst=1): state=SEED, row_w=0, rule=RULE_INIT, tick counter=0, step=0, we=0, seed_sel=0, frame_done=0, debouncers cleared to "released".
- Tick counter: counts 0..TICK_DIV-1 and wraps.
  - Internal tick is high when count==TICK_DIV-1.
  - step is registered; it rises on the edge following a tick.
  - First step occurs exactly TICK_DIV cycles after reset release.
  - Step period is TICK_DIV cycles.
- States:
  - SEED:
    - seed_sel=0, row_w=0.
    - On step: go to RUN with row_w=1.
  - RUN:
    - seed_sel=1.
    - On step: if row_w==ROWS-1, go to HOLD; otherwise increment row_w.
    - Writes happen for row_w = 1..ROWS-1.
  - HOLD:
    - seed_sel=1, step=0, we=0, frame_done=1, row_w holds ROWS-1.
    - Counts ticks; after HOLD_TICKS ticks, go to SEED with row_w=0.
    - If HOLD_TICKS=0, stays in HOLD until a rule change.
- A full frame is exactly ROWS write strobes: row 0 is the seed, then rows 1..ROWS-1.
- Switch path, per switch:
  - Two-flop synchroniser, then a debounce counter.
  - The counter resets on any change of the synchronised level.
  - The new level is accepted when the counter saturates at 2^DEBOUNCE_BITS-1.
  - A press event is one cycle on an accepted 0→1 transition.
  - Releases produce no event.
- Rule update, on the press event:
  - sw1 only: rule = rule+1 mod 256 (255→0).
  - sw2 only: rule = rule-1 mod 256 (0→255).
  - Both in the same cycle: rule unchanged, no restart.
- Restart on a rule change:
  - On the next edge: state=SEED, row_w=0, tick counter=0, frame_done=0.
  - Pending step is suppressed; step is forced to 0 that cycle.
  - The next step comes TICK_DIV cycles later.
  - Applies from any state.
- If a rule change and a tick coincide, the restart wins; no write occurs that cycle.
- rule is only ever modified by switch events; it is stable between them.
- Reset asserted mid-frame: all outputs return immediately to reset values and no write is issued.

Test Plan:
- ROWS=4, TICK_DIV=4, HOLD_TICKS=2, DEBOUNCE_BITS=2, rst pulse then idle → step at cycles 4, 8, 12, 16 with row_w=0, 1, 2, 3 and seed_sel=0, 1, 1, 1. frame_done goes high after cycle 16. Next seed write (row 0, seed_sel=0) occurs at cycle 28.
- rule=30; hold sw1 high 8 cycles → exactly one increment to 31. In RUN at row_w=2, a restart occurs: row_w=0, seed_sel=0, next step 4 cycles later.
- rule=0; sw2 press → rule=255. rule=255; sw1 press → rule=0. Both switches pressed in the same cycle → rule unchanged, no restart.
- sw1 toggling every 2 cycles for 20 cycles (shorter than the debounce window) → no rule change, no restart.
- A press event aligned with a tick cycle → step stays 0 that cycle, row_w=0, no write.
- rst asserted asynchronously mid-RUN (between edges) → step, we, row_w, and seed_sel go to 0 and rule goes to 30 without waiting for clk. After release, the first step occurs at TICK_DIV.
